// File: rtl/video_pkg.sv
// Shared video constants: 640x480@60 timing and frame buffer geometry.
// Used by the scanout, the renderer and the frame buffer.
package video_pkg;
  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam bit SYNC_POL  = 1'b0;

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_ADDR_W = 19;
  localparam int FB_DEPTH  = H_ACTIVE * V_ACTIVE;

  // Counter width, enough for any mode up to 4095 clocks/lines.
  localparam int CNT_W     = 12;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  // Control bits travelling alongside the read data.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } vid_ctl_t;
endpackage

// File: rtl/video_timing.sv
// Raster h/v counters with sync/active flags and frame strobes.
// Ports: clk, rst_n, ce in; active, hs_on, vs_on, sof, eof, vbs out.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACT = video_pkg::H_ACTIVE,
  parameter int H_F   = video_pkg::H_FP,
  parameter int H_S   = video_pkg::H_SYNC,
  parameter int H_B   = video_pkg::H_BP,
  parameter int V_ACT = video_pkg::V_ACTIVE,
  parameter int V_F   = video_pkg::V_FP,
  parameter int V_S   = video_pkg::V_SYNC,
  parameter int V_B   = video_pkg::V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  output logic active,
  output logic hs_on,
  output logic vs_on,
  output logic sof,
  output logic eof,
  output logic vbs
);
  localparam int HT  = H_ACT + H_F + H_S + H_B;
  localparam int VT  = V_ACT + V_F + V_S + V_B;
  localparam int HS0 = H_ACT + H_F;
  localparam int HS1 = H_ACT + H_F + H_S;
  localparam int VS0 = V_ACT + V_F;
  localparam int VS1 = V_ACT + V_F + V_S;

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic h_end, v_end;

  assign h_end = (h_q == CNT_W'(HT - 1));
  assign v_end = (v_q == CNT_W'(VT - 1));

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ce) begin
      if (h_end) begin
        h_d = '0;
        v_d = v_end ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign active = (h_q < CNT_W'(H_ACT)) &&
                  (v_q < CNT_W'(V_ACT));
  assign hs_on  = (h_q >= CNT_W'(HS0)) &&
                  (h_q <  CNT_W'(HS1));
  assign vs_on  = (v_q >= CNT_W'(VS0)) &&
                  (v_q <  CNT_W'(VS1));
  assign sof    = (h_q == '0) && (v_q == '0);
  assign eof    = h_end && v_end;
  // First clock of vertical blanking: the only legal swap point.
  assign vbs    = (h_q == '0) &&
                  (v_q == CNT_W'(V_ACT));
endmodule

// File: rtl/frame_scanout.sv
// Frame buffer read master: raster addressing, sync/data alignment
// and tear-free buffer swap arbitration at the start of vblank.
module frame_scanout
  import video_pkg::*;
#(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP,
  parameter bit SYNC_POL = video_pkg::SYNC_POL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  output logic [FB_ADDR_W-1:0] rd_addr,
  input  logic                 rd_data,
  output logic                 swap,
  input  logic                 swap_req,
  output logic                 swap_done,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 pixel,
  output logic                 frame_start
);
  localparam int       DEPTH = H_ACTIVE * V_ACTIVE;
  localparam fb_addr_t LAST  = FB_ADDR_W'(DEPTH - 1);

  logic active, hs_on, vs_on, sof, eof, vbs;

  video_timing #(
    .H_ACT(H_ACTIVE), .H_F(H_FP),
    .H_S(H_SYNC),     .H_B(H_BP),
    .V_ACT(V_ACTIVE), .V_F(V_FP),
    .V_S(V_SYNC),     .V_B(V_BP)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .active (active),
    .hs_on  (hs_on),
    .vs_on  (vs_on),
    .sof    (sof),
    .eof    (eof),
    .vbs    (vbs)
  );

  fb_addr_t addr_q, addr_d;
  vid_ctl_t s1_q, s1_d;
  logic     hsync_q, hsync_d;
  logic     vsync_q, vsync_d;
  logic     de_q, de_d;
  logic     pixel_q, pixel_d;
  logic     fs_q, fs_d;
  logic     pend_q, pend_d;
  logic     fire;

  // Same-cycle requests at the swap point are honoured too.
  assign fire = ce & vbs & (pend_q | swap_req);

  always_comb begin
    addr_d  = addr_q;
    s1_d    = s1_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    pixel_d = pixel_q;
    fs_d    = fs_q;
    pend_d  = pend_q;
    if (ce) begin
      // Saturate on the last pixel; blanking holds the address.
      if (eof) begin
        addr_d = '0;
      end else if (active && (addr_q != LAST)) begin
        addr_d = addr_q + 1'b1;
      end
      s1_d    = '{hs: hs_on, vs: vs_on,
                  de: active, fs: sof};
      hsync_d = s1_q.hs ? SYNC_POL : ~SYNC_POL;
      vsync_d = s1_q.vs ? SYNC_POL : ~SYNC_POL;
      de_d    = s1_q.de;
      pixel_d = s1_q.de & rd_data;
      fs_d    = s1_q.fs;
      pend_d  = fire ? 1'b0 : (pend_q | swap_req);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      s1_q    <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      pixel_q <= 1'b0;
      fs_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      s1_q    <= s1_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      pixel_q <= pixel_d;
      fs_q    <= fs_d;
      pend_q  <= pend_d;
    end
  end

  assign rd_addr     = addr_q;
  assign swap        = fire;
  assign swap_done   = fire;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench: small-mode scanout against a positional model,
// plus a default-timing instance for line-level counts.
module tb_frame_scanout;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = 16, VT = 10, FT = 160;
  localparam int LASTA = 47;
  localparam int SWP = 96;

  logic clk = 1'b0;
  logic rst_n, ce, swap_req;
  logic rd_data = 1'b0;
  logic [18:0] rd_addr;
  logic swap, swap_done, hsync, vsync, de, pixel, frame_start;

  logic d_rd_data = 1'b0;
  logic [18:0] d_rd_addr;
  logic d_swap, d_swap_done, d_hsync, d_vsync, d_de, d_pixel, d_fs;

  int checks = 0, fails = 0;
  int k = 0;
  int nswap = 0, swap_pos = -1;
  int mm_addr = 0, mm_hs = 0, mm_vs = 0, mm_de = 0;
  int mm_px = 0, mm_fs = 0, mm_sd = 0;
  int s_hs = 0, s_vs = 0, s_de = 0;
  int d_hs = 0, d_vs = 0, d_de_n = 0;
  bit p1 = 1'b0;

  always #5 clk = ~clk;

  // One-cycle-latency frame buffer holding bit0 of the address.
  always @(posedge clk) if (ce) rd_data <= rd_addr[0];

  frame_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .swap(swap), .swap_req(swap_req), .swap_done(swap_done),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pixel(pixel), .frame_start(frame_start)
  );

  frame_scanout u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .rd_addr(d_rd_addr), .rd_data(d_rd_data),
    .swap(d_swap), .swap_req(1'b0), .swap_done(d_swap_done),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
    .pixel(d_pixel), .frame_start(d_fs)
  );

  function automatic int ph(int s); return s % HT; endfunction
  function automatic int pv(int s); return (s / HT) % VT; endfunction
  function automatic bit act(int s);
    return ph(s) < HA && pv(s) < VA;
  endfunction
  function automatic int eaddr(int s);
    int t;
    if (pv(s) >= VA) return LASTA;
    t = pv(s) * HA + ((ph(s) < HA) ? ph(s) : HA);
    return (t > LASTA) ? LASTA : t;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; checks outputs for state k.
  task automatic cyc(input logic c, input logic r);
    logic e_hs, e_vs, e_de, e_px, e_fs;
    int s;
    ce = c;
    swap_req = r;
    #1;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
    e_px = 1'b0; e_fs = 1'b0;
    if (k >= 2) begin
      s = k - 2;
      e_de = act(s);
      e_hs = !(ph(s) >= HA + HF && ph(s) < HA + HF + HS);
      e_vs = !(pv(s) >= VA + VF && pv(s) < VA + VF + VS);
      e_px = e_de & eaddr(s)[0];
      e_fs = (s % FT) == 0;
    end
    if (int'(rd_addr) != eaddr(k)) mm_addr++;
    if (hsync !== e_hs) mm_hs++;
    if (vsync !== e_vs) mm_vs++;
    if (de !== e_de) mm_de++;
    if (pixel !== e_px) mm_px++;
    if (frame_start !== e_fs) mm_fs++;
    if (swap_done !== swap) mm_sd++;
    if (swap === 1'b1) begin
      nswap++;
      swap_pos = k % FT;
    end
    if (p1 && k >= 2 && k < 1602) begin
      if (!hsync) s_hs++;
      if (!vsync) s_vs++;
      if (de) s_de++;
      if (!d_hsync) d_hs++;
      if (!d_vsync) d_vs++;
      if (d_de) d_de_n++;
    end
    @(posedge clk);
    if (c) k++;
    @(negedge clk);
  endtask

  task automatic run_to(int h, int v);
    int n = 0;
    while ((ph(k) != h || pv(k) != v) && n < 400) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    if (n >= 400) begin
      fails++;
      $error("FAIL run_to timeout h=%0d v=%0d", h, v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce = 1'b1;
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_vec",
        int'({rd_addr, hsync, vsync, de, pixel, frame_start, swap}),
        int'({19'd0, 6'b110000}));
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // Ten small frames / two default lines of free-running video.
    p1 = 1'b1;
    repeat (1602) cyc(1'b1, 1'b0);
    p1 = 1'b0;
    chk("s_hs_low", s_hs, 300);
    chk("s_vs_low", s_vs, 320);
    chk("s_de_cnt", s_de, 480);
    chk("d_hs_low", d_hs, 192);
    chk("d_vs_low", d_vs, 0);
    chk("d_de_cnt", d_de_n, 1280);
    chk("p1_noswap", nswap, 0);

    run_to(7, 5);
    chk("addr_last", int'(rd_addr), LASTA);
    run_to(12, 8);
    chk("addr_hold", int'(rd_addr), LASTA);
    run_to(0, 0);
    chk("addr_wrap", int'(rd_addr), 0);

    // Single request mid-frame.
    nswap = 0;
    run_to(3, 2);
    cyc(1'b1, 1'b1);
    run_to(1, 7);
    chk("single_cnt", nswap, 1);
    chk("single_pos", swap_pos, SWP);
    nswap = 0;
    run_to(0, 0);
    run_to(1, 7);
    chk("single_next", nswap, 0);

    // Merged requests, including one at the swap point.
    nswap = 0;
    run_to(2, 1);
    cyc(1'b1, 1'b1);
    run_to(5, 3);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    run_to(0, 6);
    cyc(1'b1, 1'b1);
    run_to(1, 7);
    chk("merge_cnt", nswap, 1);
    chk("merge_pos", swap_pos, SWP);
    nswap = 0;
    run_to(0, 0);
    run_to(1, 7);
    chk("merge_next", nswap, 0);

    // Request only in the swap-point cycle.
    nswap = 0;
    run_to(0, 6);
    cyc(1'b1, 1'b1);
    run_to(1, 7);
    chk("same_cnt", nswap, 1);
    nswap = 0;
    run_to(0, 0);
    run_to(1, 7);
    chk("same_next", nswap, 0);

    // Half-rate ce across the swap point.
    nswap = 0;
    run_to(0, 5);
    cyc(1'b1, 1'b1);
    run_to(14, 5);
    repeat (12) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    chk("ce_cnt", nswap, 1);
    chk("ce_pos", swap_pos, SWP);

    // Asynchronous reset mid-frame with a request pending.
    run_to(4, 4);
    cyc(1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        int'({rd_addr, hsync, vsync, de, pixel, frame_start, swap}),
        int'({19'd0, 6'b110000}));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    nswap = 0;
    run_to(1, 7);
    chk("rst_drop", nswap, 0);
    run_to(0, 0);

    chk("mm_addr", mm_addr, 0);
    chk("mm_hsync", mm_hs, 0);
    chk("mm_vsync", mm_vs, 0);
    chk("mm_de", mm_de, 0);
    chk("mm_pixel", mm_px, 0);
    chk("mm_fstart", mm_fs, 0);
    chk("mm_swapdone", mm_sd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
